// File: rtl/flanger_mod_delay.sv
// Modulated feedback delay line (flanger/chorus) built around one single-port,
// synchronous-read sample buffer; one sample is processed every three clocks.
module flanger_mod_delay #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int BASE_DELAY  = 64,
  parameter int DEPTH_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic [5:0]               lfo_val,
  input  logic [1:0]               mix_sel,
  input  logic [2:0]               fb_shift,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_sample
);

  typedef enum logic [1:0] {CLEAR, IDLE, RD, WR} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  function automatic logic signed [DATA_W:0] sext(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;

  logic signed [DATA_W-1:0] dry_q;
  logic [1:0]               mix_q;
  logic [2:0]               fb_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic signed [DATA_W-1:0] wet_q;

  logic signed [DATA_W-1:0] mem_q [0:2**ADDR_W-1];
  logic                     mem_we;
  logic                     mem_re;
  logic [ADDR_W-1:0]        mem_addr;
  logic signed [DATA_W-1:0] mem_wdata;

  logic                     accept;
  logic [ADDR_W-1:0]        dly;
  logic signed [DATA_W-1:0] fbv;
  logic signed [DATA_W:0]   fb_sum;
  logic signed [DATA_W:0]   mix_sum;
  logic signed [DATA_W-1:0] mix_val;

  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

  // Legal parameters keep the delay below 2^ADDR_W, so ADDR_W bits hold it exactly.
  assign dly = ADDR_W'(BASE_DELAY) + (ADDR_W'(lfo_val) << DEPTH_SHIFT);

  // ---- Stage boundary: acceptance latches the dry sample and controls ----
  always_ff @(posedge clk) begin
    if (accept) begin
      dry_q     <= in_sample;
      mix_q     <= mix_sel;
      fb_q      <= fb_shift;
      rd_addr_q <= wr_ptr_q - dly;
    end
  end

  // ---- Stage boundary: buffer port (read in RD, write in WR/CLEAR) ----
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_addr] <= mem_wdata;
    if (mem_re)
      wet_q <= mem_q[mem_addr];
  end

  always_comb begin
    fbv     = (fb_q == 3'd0) ? '0 : (wet_q >>> fb_q);
    fb_sum  = sext(dry_q) + sext(fbv);
    mix_sum = sext(dry_q) + sext(wet_q);
    case (mix_q)
      2'd0:    mix_val = dry_q;
      2'd1:    mix_val = wet_q;
      2'd2:    mix_val = DATA_W'(mix_sum >>> 1);
      default: mix_val = sat(mix_sum);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = wr_ptr_q;
    mem_wdata    = '0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR)
          state_d = IDLE;
      end
      IDLE: begin
        if (accept)
          state_d = RD;
      end
      RD: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr_q;
        state_d  = WR;
      end
      WR: begin
        mem_we       = 1'b1;
        mem_addr     = wr_ptr_q;
        mem_wdata    = sat(fb_sum);
        out_sample_d = mix_val;
        out_valid_d  = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        state_d      = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // ---- Stage boundary: control and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

endmodule

// File: tb/tb_flanger_mod_delay.sv
// Directed bench for flanger_mod_delay: clear, fixed/modulated delay, feedback,
// mix/saturation, back-to-back handshake and reset during a read.
module tb_flanger_mod_delay;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_sample = '0;
  logic [5:0]         lfo_val = '0;
  logic [1:0]         mix_sel = '0;
  logic [2:0]         fb_shift = '0;
  logic               out_valid;
  logic signed [15:0] out_sample;

  int total = 0;
  int bad   = 0;

  flanger_mod_delay #(.DATA_W(16), .ADDR_W(8), .BASE_DELAY(64), .DEPTH_SHIFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .lfo_val(lfo_val), .mix_sel(mix_sel), .fb_shift(fb_shift),
    .out_valid(out_valid), .out_sample(out_sample)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Holds reset low briefly, checks reset outputs, then times the clear phase.
  task automatic do_reset(input string tag);
    int n;
    int pulses;
    pulses = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk({tag, "_rst_ready"}, int'(in_ready), 0);
    chk({tag, "_rst_ovalid"}, int'(out_valid), 0);
    chk({tag, "_rst_osample"}, int'(out_sample), 0);
    chk({tag, "_rst_wrptr"}, int'(dut.wr_ptr_q), 0);
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
      if (out_valid) pulses++;
    end
    chk({tag, "_clear_cycles"}, n, 256);
    chk({tag, "_clear_pulses"}, pulses, 0);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen.
  task automatic do_sample(input logic signed [15:0] s, input logic [5:0] lfo,
                           input logic [1:0] mix, input logic [2:0] fb,
                           output logic signed [15:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", n, 0);
    in_valid = 1'b1;
    in_sample = s;
    lfo_val = lfo;
    mix_sel = mix;
    fb_shift = fb;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("out_timeout", n, 0);
    y = out_sample;
  endtask

  // Impulse of 1000 after 'pre' zeros; expected output 1000>>(m-1) at k = m*d.
  task automatic imp_test(input string tag, input int lfo, input int fb,
                          input int pre, input int nacc, input int d);
    logic signed [15:0] y;
    int exp;
    do_reset(tag);
    for (int k = -pre; k < nacc; k++) begin
      do_sample((k == 0) ? 16'sd1000 : 16'sd0, 6'(lfo), 2'd1, 3'(fb), y);
      exp = 0;
      if (k > 0 && (k % d) == 0 && (fb != 0 || k == d))
        exp = 1000 >>> ((k / d) - 1);
      chk($sformatf("%s_k%0d", tag, k), int'(y), exp);
    end
  endtask

  initial begin
    logic signed [15:0] y;
    int acc;
    int outs;
    int exp_o;

    // Reset state and cleared buffer
    do_reset("init");
    for (int k = 0; k < 10; k++) begin
      do_sample(16'sd0, 6'd0, 2'd1, 3'd0, y);
      chk($sformatf("zero_%0d", k), int'(y), 0);
    end

    imp_test("fix64", 0, 0, 0, 70, 64);
    imp_test("mod84", 10, 0, 0, 90, 84);
    imp_test("mod190", 63, 0, 100, 200, 190);
    imp_test("fb1", 0, 1, 0, 200, 64);

    // Mix modes and saturation
    do_reset("mix");
    do_sample(16'sd30000, 6'd0, 2'd0, 3'd0, y);
    chk("mix_dry", int'(y), 30000);
    do_sample(16'sd30000, 6'd0, 2'd1, 3'd0, y);
    chk("mix_wet1", int'(y), 0);
    do_sample(-16'sd30000, 6'd0, 2'd1, 3'd0, y);
    chk("mix_wet2", int'(y), 0);
    for (int k = 3; k < 64; k++) do_sample(16'sd0, 6'd0, 2'd1, 3'd0, y);
    do_sample(16'sd30000, 6'd0, 2'd3, 3'd0, y);
    chk("sat_pos", int'(y), 32767);
    do_sample(16'sd30000, 6'd0, 2'd2, 3'd0, y);
    chk("avg", int'(y), 30000);
    do_sample(-16'sd30000, 6'd0, 2'd3, 3'd0, y);
    chk("sat_neg", int'(y), -32768);

    // Continuous in_valid: one acceptance every third cycle
    do_reset("hs");
    acc = 0;
    outs = 0;
    mix_sel = 2'd0;
    fb_shift = 3'd0;
    lfo_val = 6'd0;
    for (int i = 0; i < 33; i++) begin
      in_valid = 1'b1;
      in_sample = 16'(100 + i);
      if (in_ready) acc++;
      if (out_valid) begin
        outs++;
        chk($sformatf("hs_out%0d", i), int'(out_sample), 100 + i - 3);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("hs_accepts", acc, 11);
    chk("hs_outputs", outs, 10);
    exp_o = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        exp_o++;
        chk("hs_last", int'(out_sample), 130);
      end
      @(negedge clk);
    end
    chk("hs_last_seen", exp_o, 1);

    // Reset while a sample is in RD
    do_reset("rd");
    for (int k = 0; k < 5; k++) do_sample(16'sd5, 6'd0, 2'd0, 3'd0, y);
    chk("rd_wrptr_pre", int'(dut.wr_ptr_q), 5);
    in_valid = 1'b1;
    in_sample = 16'sd777;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rd_abort_ready", int'(in_ready), 0);
    chk("rd_abort_ovalid", int'(out_valid), 0);
    do_reset("rd_abort");
    chk("rd_wrptr_post", int'(dut.wr_ptr_q), 0);
    do_sample(16'sd0, 6'd0, 2'd1, 3'd0, y);
    chk("rd_after", int'(y), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flanger_mod_delay.md
# flanger_mod_delay

Modulated feedback delay line for the audio-loopback effects chain. It sits directly downstream of the LFO: each accepted audio sample is written into a circular buffer, and a tap is read back at a delay of `BASE_DELAY + (lfo_val << DEPTH_SHIFT)` samples. The delayed tap is fed back into the buffer and mixed with the dry signal to produce flanger/chorus output. The buffer is single-port and synchronous-read, so it maps to one Gowin BSRAM.

## Interface
- `DATA_W`, default 16: signed audio sample width.
- `ADDR_W`, default 8: buffer address width; depth is `2^ADDR_W`.
- `BASE_DELAY`, default 64: fixed delay component, in samples.
- `DEPTH_SHIFT`, default 1: left shift applied to `lfo_val`.
  - Legal only when `BASE_DELAY + (63 << DEPTH_SHIFT) <= 2^ADDR_W - 1`.
  - `BASE_DELAY >= 1`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_sample` is valid this cycle.
- `in_ready` out 1: block can accept a sample. Combinational, equal to `(state == IDLE)`.
- `in_sample` in DATA_W: signed dry input.
- `lfo_val` in 6: unsigned modulation value, 0..63, from the LFO `sin_out`. Sampled only at acceptance.
- `mix_sel` in 2: output mix select, latched at acceptance.
  - 0 = dry
  - 1 = wet
  - 2 = (dry+wet)>>>1
  - 3 = sat(dry+wet)
- `fb_shift` in 3: feedback attenuation, latched at acceptance.
  - 0 = feedback off.
  - n = wet>>>n is added to the written sample.
- `out_valid` out 1: one-cycle pulse; `out_sample` is valid.
- `out_sample` out DATA_W: signed processed output. Holds its value until the next `out_valid`.

## Operation
- States: CLEAR, IDLE, RD, WR.
- CLEAR
  - Entered on reset.
  - A clear counter writes 0 to every address 0..2^ADDR_W-1, one per cycle.
  - After address 2^ADDR_W-1 is written, the next state is IDLE. CLEAR lasts exactly 2^ADDR_W cycles after reset release.
  - `in_ready` = 0 throughout.
- IDLE
  - On `in_valid && in_ready`:
    - latch `in_sample`, `mix_sel` and `fb_shift`;
    - compute `d = BASE_DELAY + (lfo_val << DEPTH_SHIFT)`, zero-extended to ADDR_W+1;
    - compute `rd_addr = (wr_ptr - d) mod 2^ADDR_W`;
    - go to RD.
  - With `in_valid` = 0, stay in IDLE.
- RD
  - Memory read of `rd_addr` is issued; data is registered as `wet`.
  - Next state is WR.
- WR
  - `fbv = (fb_shift == 0) ? 0 : wet >>> fb_shift`, arithmetic shift.
  - `mem[wr_ptr] <= sat(dry + fbv)`.
  - `out_sample <=` the mix selected by `mix_sel`.
  - `out_valid <= 1`.
  - `wr_ptr <= wr_ptr + 1`, wrapping modulo 2^ADDR_W.
  - Next state is IDLE.
- Arithmetic and width rules:
  - All sums are formed at DATA_W+1 bits.
  - `sat()` clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Mode 2 shifts the DATA_W+1-bit sum arithmetically and cannot overflow.
- `in_valid` outside IDLE is ignored and the sample is dropped. Upstream must honour `in_ready`.
- Delay semantics: the output for the sample written at pointer p uses `mem[p-d]`, i.e. the sample accepted d acceptances earlier.
- Reset mid-operation (any state):
  - Immediately go to CLEAR with `wr_ptr` = 0, `out_valid` = 0, `out_sample` = 0.
  - The whole buffer is re-cleared; an in-flight sample is discarded.

## Timing
- Reset values:
  - state = CLEAR, `wr_ptr` = 0, clear counter = 0
  - `in_ready` = 0, `out_valid` = 0, `out_sample` = 0
- Acceptance edge E0 (IDLE, `in_valid` = 1) → RD during E0..E1 → WR during E1..E2.
- `out_valid` is high in the cycle following E2, i.e. latency of 2 edges.
- `in_ready` returns high in that same cycle. Maximum throughput is 1 sample per 3 clocks.
- `out_valid` is exactly one cycle wide. It is 0 in every other cycle, including throughout CLEAR.
- Memory has one port: the read happens in RD, the write in WR, with no same-cycle read/write.

## Test plan
- Reset release:
  - Assert `in_ready` = 0 for exactly 256 cycles, then 1.
  - With `mix_sel` = 1, feed 10 zero samples → all outputs are 0 (buffer cleared).
- Fixed delay:
  - `lfo_val` = 0, `fb_shift` = 0, `mix_sel` = 1.
  - Impulse 1000 at acceptance 0, then zeros → `out_sample` = 1000 only at acceptance 64.
- Modulated delay:
  - `lfo_val` = 10 (d = 84) → the impulse appears at acceptance 84.
  - `lfo_val` = 63 (d = 190) → the impulse appears at acceptance 190, crossing `wr_ptr` wrap.
- Feedback:
  - `fb_shift` = 1, `lfo_val` = 0, `mix_sel` = 1.
  - Impulse 1000 → outputs 1000, 500, 250 at acceptances 64, 128, 192.
- Saturation/mix:
  - `mix_sel` = 3 with dry = 30000 and wet = 30000 → 32767.
  - `mix_sel` = 2 → 30000.
  - Dry = -30000, wet = -30000 with `mix_sel` = 3 → -32768.
- Handshake/reset:
  - `in_valid` held high continuously → exactly one acceptance per 3 cycles; extra samples are not written.
  - Assert `rst_n` low during RD → `out_valid` never pulses for that sample; CLEAR restarts (256 cycles) and `wr_ptr` = 0.
